// File: rtl/risc16_mem_arbiter.sv
// Arbiter sharing one single-port unified memory between the RISC16 fetch and data ports.
// Define ARB_ROUND_ROBIN_EN to replace data-priority/starvation arbitration with round-robin on contention.
module risc16_mem_arbiter #(
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [15:0] i_rdata,
  input  logic        d_req,
  input  logic [15:0] d_addr,
  input  logic [1:0]  d_we,
  input  logic [15:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [15:0] d_rdata,
  output logic [15:0] m_addr,
  output logic        m_oe,
  output logic        m_we0,
  output logic        m_we1,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata
);

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  logic   contended;
  logic   i_win;        // fetch wins a contended cycle
  owner_e issue_owner;

  assign contended = i_req && d_req;

  // NOTE: every output of this block is given a default first, so no path leaves a latch behind.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (contended) begin
        i_gnt = i_win;
        d_gnt = !i_win;
      end else begin
        i_gnt = i_req;
        d_gnt = d_req;
      end
    end
  end

  always_comb begin
    m_addr  = 16'h0;
    m_oe    = 1'b0;
    m_we0   = 1'b0;
    m_we1   = 1'b0;
    m_wdata = 16'h0;
    if (i_gnt) begin
      m_addr = i_addr;
      m_oe   = 1'b1;
    end else if (d_gnt) begin
      m_addr = d_addr;
      if (d_we == 2'b00) begin
        m_oe = 1'b1;
      end else begin
        m_we0   = d_we[0];
        m_we1   = d_we[1];
        m_wdata = d_wdata;
      end
    end
  end

  assign issue_owner = d_gnt ? OWN_D : OWN_I;

  // Return pipeline: stage 0 captures each issued read, the last stage steers m_rdata.
  logic [RD_LATENCY-1:0] pipe_valid;
  owner_e                pipe_owner [RD_LATENCY];

  // NOTE: sequential state uses non-blocking assignments so every stage shifts from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= m_oe;
      for (int k = 1; k < RD_LATENCY; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
      end
    end
  end

  // NOTE: owner tags are left unreset; the valid bits alone decide whether a tag means anything.
  always_ff @(posedge clk) begin
    pipe_owner[0] <= issue_owner;
    for (int k = 1; k < RD_LATENCY; k++) begin
      pipe_owner[k] <= pipe_owner[k-1];
    end
  end

  logic ret_valid;
  assign ret_valid = pipe_valid[RD_LATENCY-1] && !rst;  // reads caught by reset never return

  assign i_rvalid = ret_valid && (pipe_owner[RD_LATENCY-1] == OWN_I);
  assign d_rvalid = ret_valid && (pipe_owner[RD_LATENCY-1] == OWN_D);
  assign i_rdata  = i_rvalid ? m_rdata : 16'h0;
  assign d_rdata  = d_rvalid ? m_rdata : 16'h0;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_winner;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_winner <= OWN_D;
    end else if (contended) begin
      last_winner <= i_win ? OWN_I : OWN_D;
    end
  end

  assign i_win = (last_winner == OWN_D);
`else
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  // Counts consecutive fetch losses; at the limit fetch takes the next contended cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (i_gnt) begin
      starve_cnt <= 4'd0;
    end else if (i_req && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign i_win = (starve_cnt == STARVE_MAX);
`endif

endmodule
